// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between processor loads/stores and the
// graphics write stream; processor first, with a bounded-wait forced graphics grant.
module dmem_port_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_we,
  input  logic        cpu_re,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        cpu_stall,
  input  logic        gfx_valid,
  output logic        gfx_ready,
  input  logic [31:0] gfx_addr,
  input  logic [3:0]  gfx_we,
  input  logic [31:0] gfx_din,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic        mem_re,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]  starve_cnt;
  logic        rd_pend;
  logic [31:0] rd_hold;

  logic cpu_req;
  logic force_gfx;
  logic cpu_grant;
  logic gfx_grant;

  assign cpu_req   = cpu_re | (|cpu_we);
  assign force_gfx = gfx_valid && (starve_cnt >= LIMIT);
  assign cpu_grant = !force_gfx && cpu_req;
  assign gfx_grant = force_gfx || (!cpu_req && gfx_valid);

  always_comb begin
    mem_addr  = cpu_addr;
    mem_din   = cpu_din;
    mem_we    = 4'h0;
    mem_re    = 1'b0;
    gfx_ready = 1'b0;
    cpu_stall = 1'b0;
    cpu_dout  = rd_pend ? mem_dout : rd_hold;
    if (gfx_grant) begin
      mem_addr  = gfx_addr;
      mem_din   = gfx_din;
      mem_we    = gfx_we;
      gfx_ready = 1'b1;
      cpu_stall = cpu_req;
    end else if (cpu_grant) begin
      mem_we = cpu_we;
      mem_re = cpu_re;
    end
    // Reset masks every side-effecting output, even with requests held high.
    if (rst) begin
      mem_we    = 4'h0;
      mem_re    = 1'b0;
      gfx_ready = 1'b0;
      cpu_stall = 1'b0;
      cpu_dout  = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 8'h0;
      rd_pend    <= 1'b0;
      rd_hold    <= 32'h0;
    end else begin
      if (gfx_grant || !gfx_valid) begin
        starve_cnt <= 8'h0;
      end else if (starve_cnt < LIMIT) begin
        starve_cnt <= starve_cnt + 8'h1;
      end
      rd_pend <= cpu_grant && cpu_re;
      // Keep the last returned word so stalls and graphics cycles do not disturb it.
      if (rd_pend) begin
        rd_hold <= mem_dout;
      end
    end
  end

endmodule
